id_scroll_ctrl: RTL and testbench
=================================

ID_SCROLL_CTRL -- requirements
Module: id_scroll_ctrl

Interface
REQ-001 SHALL have parameter ID_LEN, default 8: number of decimal digits in the stored ID, range 1..16.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: number of seven-segment positions driven, range 1..16.
REQ-003 SHALL have parameter GAP, default 2: number of blank positions appended to the ID in the scroll ring.
REQ-004 SHALL have parameter SCAN_DIV, default 131072: clk100mhz cycles per scan step.
REQ-005 SHALL have parameter SCROLL_DIV, default 33333333: clk100mhz cycles per scroll step.
REQ-006 SHALL have parameter SEG_ACTIVE_HIGH, default 1: 1 means a lit segment is 1, 0 means all seg bits are inverted.
REQ-007 SHALL have port clk100mhz, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have ports key_input, key_wei, key_shuzi, key_enter and key_disp, each input, 1 bit: debounced one-cycle key pulses.
REQ-010 SHALL have port pos, output, NUM_DIGITS bits: one-hot active-high digit enable; bit i is position i, position 0 is leftmost.
REQ-011 SHALL have port seg, output, 8 bits, ordered {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port mode, output, 2 bits: 0 = IDLE, 1 = EDIT, 2 = SHOW.
REQ-013 SHALL have port id_valid, output, 1 bit: a committed ID exists.

Function
REQ-014 SHALL implement FSM states IDLE, EDIT and SHOW; mode SHALL reflect the current state.
REQ-015 SHALL act on at most one key per cycle, priority key_input > key_enter > key_disp > key_wei > key_shuzi; lower-priority pulses arriving in the same cycle are discarded.
REQ-016 key_input in any state SHALL enter EDIT, set cursor to 0 and clear the edit buffer to all 0.
REQ-017 In EDIT, key_wei SHALL set cursor to cursor+1, wrapping from ID_LEN-1 to 0.
REQ-018 In EDIT, key_shuzi SHALL increment buffer[cursor], wrapping from 9 to 0.
REQ-019 In EDIT, key_enter SHALL copy the buffer into the committed ID, set id_valid to 1 and enter IDLE.
REQ-020 key_enter outside EDIT SHALL be ignored.
REQ-021 key_disp in IDLE SHALL enter SHOW with offset 0 if id_valid is 1, and SHALL be ignored otherwise.
REQ-022 key_disp in SHOW SHALL enter IDLE; key_disp in EDIT SHALL be ignored.
REQ-023 key_wei and key_shuzi outside EDIT SHALL be ignored.
REQ-024 The scan counter SHALL advance the scan index every SCAN_DIV cycles, over 0..NUM_DIGITS-1, wrapping to 0; it SHALL run in all states.
REQ-025 pos and seg SHALL be registered and SHALL update 1 cycle after the scan index changes.
REQ-026 In IDLE, every position SHALL be blank (all segments off).
REQ-027 In EDIT, position i SHALL show buffer[base+i], where base = (cursor/NUM_DIGITS)*NUM_DIGITS; positions with index >= ID_LEN SHALL be blank; the dp of the cursor position SHALL be lit.
REQ-028 In SHOW, position i SHALL show ring[(offset+i) mod (ID_LEN+GAP)], where ring entries 0..ID_LEN-1 are the committed ID and the remaining entries are blank.
REQ-029 In SHOW, offset SHALL increment every SCROLL_DIV cycles, wrapping to 0 at ID_LEN+GAP.
REQ-030 The scroll prescaler SHALL restart at each entry to SHOW.
REQ-031 Digits 0-9 SHALL use standard encodings (0 = 0x3F … 9 = 0x6F, active-high form) with dp off except as stated in REQ-027.

Reset
REQ-032 clr asserted SHALL immediately force: state IDLE, cursor 0, buffer all 0, committed ID all 0, id_valid 0, offset 0, scan index 0, both prescalers 0, pos all 0, seg blank (polarity per SEG_ACTIVE_HIGH).
REQ-033 On clr release, the first scan step SHALL select position 0.
REQ-034 Key pulses coincident with clr SHALL have no effect.

Structure
REQ-035 Package id_disp_pkg SHALL hold the state encoding, the mode codes, the seven-segment digit constants and the blank constant.
REQ-036 Sub-module seg7_decode SHALL be combinational: 4-bit value plus blank flag plus dp in, 8-bit active-high segments out; polarity inversion SHALL be done in id_scroll_ctrl.

Verification (SCAN_DIV=4, SCROLL_DIV=16, ID_LEN=8, NUM_DIGITS=4, GAP=2)
REQ-037 Reset: assert clr mid-EDIT -> mode=0, pos=0, seg=0x00, id_valid=0 without waiting for a clock edge.
REQ-038 Entry: key_input, then key_shuzi x3, key_wei, key_shuzi x11, key_enter -> id_valid=1; committed ID digits 0,1 = 3,1 (11 increments wrap past 9 to 1).
REQ-039 Cursor paging: in EDIT, key_wei x5 -> cursor=5, base=4; position 1 shows buffer[5] with dp lit, seg=0xBF for value 0.
REQ-040 Scroll: commit ID 12345678, key_disp -> position 0 shows 1,2,3 at successive 16-cycle steps; offset 8 shows blank; offset wraps after 10 steps.
REQ-041 Priority: key_input and key_enter pulsed in the same cycle while in EDIT -> buffer cleared, id_valid unchanged.
REQ-042 Ignored key: key_disp with id_valid=0 -> mode stays 0.

Source files
------------

// File: rtl/id_disp_pkg.sv
// Shared encodings for the ID entry / scrolling display block.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package id_disp_pkg;

   // Controller states; the encoding doubles as the externally visible mode code
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EDIT = 2'd1,
      ST_SHOW = 2'd2
   } state_t;

   localparam logic [1:0] MODE_IDLE = 2'd0;
   localparam logic [1:0] MODE_EDIT = 2'd1;
   localparam logic [1:0] MODE_SHOW = 2'd2;

   // The single key acted on in a cycle after priority resolution
   typedef enum logic [2:0] {
      KEY_NONE  = 3'd0,
      KEY_INPUT = 3'd1,
      KEY_ENTER = 3'd2,
      KEY_DISP  = 3'd3,
      KEY_WEI   = 3'd4,
      KEY_SHUZI = 3'd5
   } key_t;

   // Seven-segment patterns, active-high, bit order {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DP    = 8'h80;
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;

   // Decimal digit to segment pattern; values above 9 render blank
   function automatic logic [7:0] digit_to_seg(input logic [3:0] value);
      logic [7:0] s;
      s = SEG_BLANK;
      case (value)
         4'd0: s = SEG_0;
         4'd1: s = SEG_1;
         4'd2: s = SEG_2;
         4'd3: s = SEG_3;
         4'd4: s = SEG_4;
         4'd5: s = SEG_5;
         4'd6: s = SEG_6;
         4'd7: s = SEG_7;
         4'd8: s = SEG_8;
         4'd9: s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment decoder: digit value plus blank and dp flags to active-high segments.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
   import id_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg
);

   // Pick the digit pattern (or blank) and overlay the decimal point
   always_comb begin
      seg = blank ? SEG_BLANK : digit_to_seg(value);
      if (dp) begin
         seg = seg | SEG_DP;
      end
   end

endmodule

// File: rtl/id_scroll_ctrl.sv
// ID entry keypad controller with multiplexed seven-segment display (edit view and scrolling view).
// Latency: key effect visible in state after 1 cycle; pos/seg registered 1 cycle after scan index/state.
// Backpressure: none; at most one key pulse acts per cycle, the rest of that cycle's pulses are dropped.
module id_scroll_ctrl
   import id_disp_pkg::*;
#(
   parameter int ID_LEN          = 8,
   parameter int NUM_DIGITS      = 8,
   parameter int GAP             = 2,
   parameter int SCAN_DIV        = 131072,
   parameter int SCROLL_DIV      = 33333333,
   parameter int SEG_ACTIVE_HIGH = 1
)(
   input  logic                  clk100mhz,
   input  logic                  clr,
   input  logic                  key_input,
   input  logic                  key_wei,
   input  logic                  key_shuzi,
   input  logic                  key_enter,
   input  logic                  key_disp,
   output logic [NUM_DIGITS-1:0] pos,
   output logic [7:0]            seg,
   output logic [1:0]            mode,
   output logic                  id_valid
);

   localparam int CUR_W    = (ID_LEN > 1) ? $clog2(ID_LEN) : 1;
   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int RING_LEN = ID_LEN + GAP;
   localparam int OFF_W    = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
   localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   // Segment value driven while blanked or in reset, in output polarity
   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? SEG_BLANK : ~SEG_BLANK;

   state_t               state_q;
   state_t               state_d;
   key_t                 key_sel;
   logic                 enter_show;

   logic [CUR_W-1:0]     cursor_q;
   logic [3:0]           edit_buf_q [ID_LEN];
   logic [3:0]           id_q       [ID_LEN];
   logic                 id_valid_q;

   logic [OFF_W-1:0]     offset_q;
   logic [SCROLL_W-1:0]  scroll_cnt_q;

   logic [SCAN_W-1:0]    scan_cnt_q;
   logic [IDX_W-1:0]     scan_idx_q;
   logic                 scan_run_q;

   int                   disp_base;
   int                   disp_idx;
   logic [3:0]           disp_val;
   logic                 disp_blank;
   logic                 disp_dp;
   logic [7:0]           seg_raw;

   // Resolve simultaneous key pulses down to the single highest-priority key
   always_comb begin
      key_sel = KEY_NONE;
      if (key_input) begin
         key_sel = KEY_INPUT;
      end else if (key_enter) begin
         key_sel = KEY_ENTER;
      end else if (key_disp) begin
         key_sel = KEY_DISP;
      end else if (key_wei) begin
         key_sel = KEY_WEI;
      end else if (key_shuzi) begin
         key_sel = KEY_SHUZI;
      end
   end

   // Next-state logic; enter_show flags the IDLE->SHOW transition for the scroll restart
   always_comb begin
      state_d    = state_q;
      enter_show = 1'b0;
      case (key_sel)
         KEY_INPUT: state_d = ST_EDIT;
         KEY_ENTER: begin
            if (state_q == ST_EDIT) begin
               state_d = ST_IDLE;
            end
         end
         KEY_DISP: begin
            if ((state_q == ST_IDLE) && id_valid_q) begin
               state_d    = ST_SHOW;
               enter_show = 1'b1;
            end else if (state_q == ST_SHOW) begin
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk100mhz or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Edit buffer, cursor and committed ID updates driven by the selected key
   always_ff @(posedge clk100mhz or posedge clr) begin
      if (clr) begin
         cursor_q   <= '0;
         id_valid_q <= 1'b0;
         for (int i = 0; i < ID_LEN; i++) begin
            edit_buf_q[i] <= 4'd0;
            id_q[i]       <= 4'd0;
         end
      end else begin
         case (key_sel)
            KEY_INPUT: begin
               cursor_q <= '0;
               for (int i = 0; i < ID_LEN; i++) begin
                  edit_buf_q[i] <= 4'd0;
               end
            end
            KEY_ENTER: begin
               if (state_q == ST_EDIT) begin
                  id_valid_q <= 1'b1;
                  for (int i = 0; i < ID_LEN; i++) begin
                     id_q[i] <= edit_buf_q[i];
                  end
               end
            end
            KEY_WEI: begin
               if (state_q == ST_EDIT) begin
                  cursor_q <= (cursor_q == CUR_W'(ID_LEN - 1)) ? '0 : cursor_q + CUR_W'(1);
               end
            end
            KEY_SHUZI: begin
               if (state_q == ST_EDIT) begin
                  edit_buf_q[cursor_q] <= (edit_buf_q[cursor_q] == 4'd9) ? 4'd0
                                                                        : edit_buf_q[cursor_q] + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Scan prescaler and digit index; the first tick after reset only arms the
   // scanner so that position 0 is the first one shown
   always_ff @(posedge clk100mhz or posedge clr) begin
      if (clr) begin
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         scan_run_q <= 1'b0;
      end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt_q <= '0;
         if (!scan_run_q) begin
            scan_run_q <= 1'b1;
         end else if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            scan_idx_q <= '0;
         end else begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
         end
      end else begin
         scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
   end

   // Scroll prescaler and ring offset; both restart whenever SHOW is entered
   always_ff @(posedge clk100mhz or posedge clr) begin
      if (clr) begin
         scroll_cnt_q <= '0;
         offset_q     <= '0;
      end else if (enter_show) begin
         scroll_cnt_q <= '0;
         offset_q     <= '0;
      end else if (state_q == ST_SHOW) begin
         if (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1)) begin
            scroll_cnt_q <= '0;
            offset_q     <= (offset_q == OFF_W'(RING_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
         end else begin
            scroll_cnt_q <= scroll_cnt_q + SCROLL_W'(1);
         end
      end
   end

   // Choose what the currently scanned position shows: edit page, scroll ring, or blank
   always_comb begin
      disp_base  = 0;
      disp_idx   = 0;
      disp_val   = 4'd0;
      disp_blank = 1'b1;
      disp_dp    = 1'b0;
      case (state_q)
         ST_EDIT: begin
            // The page holding the cursor is shown; NUM_DIGITS positions per page
            disp_base = (int'(cursor_q) / NUM_DIGITS) * NUM_DIGITS;
            disp_idx  = disp_base + int'(scan_idx_q);
            if (disp_idx < ID_LEN) begin
               disp_val   = edit_buf_q[CUR_W'(disp_idx)];
               disp_blank = 1'b0;
            end
            disp_dp = (disp_idx == int'(cursor_q));
         end
         ST_SHOW: begin
            // Ring is the committed ID followed by GAP blank entries
            disp_idx = (int'(offset_q) + int'(scan_idx_q)) % RING_LEN;
            if (disp_idx < ID_LEN) begin
               disp_val   = id_q[CUR_W'(disp_idx)];
               disp_blank = 1'b0;
            end
         end
         default: ;
      endcase
   end

   seg7_decode u_seg7_decode (
      .value (disp_val),
      .blank (disp_blank),
      .dp    (disp_dp),
      .seg   (seg_raw)
   );

   // Register digit enable and segments; held dark until the scanner is armed
   always_ff @(posedge clk100mhz or posedge clr) begin
      if (clr) begin
         pos <= '0;
         seg <= SEG_OFF;
      end else if (scan_run_q) begin
         pos <= NUM_DIGITS'(1) << scan_idx_q;
         seg <= (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
      end
   end

   // Mode code follows the controller state
   always_comb begin
      mode = MODE_IDLE;
      case (state_q)
         ST_EDIT: mode = MODE_EDIT;
         ST_SHOW: mode = MODE_SHOW;
         default: mode = MODE_IDLE;
      endcase
   end

   assign id_valid = id_valid_q;

endmodule

// File: tb/tb_id_scroll_ctrl.sv
// Scoreboard bench for id_scroll_ctrl: driver updates a behavioural model and queues expected outputs.
// Latency: one expected record per clock edge, checked on the following falling edge.
// Backpressure: none.
`timescale 1ns/1ps
module tb_id_scroll_ctrl;

   localparam int ID_LEN     = 8;
   localparam int NUM_DIGITS = 4;
   localparam int GAP        = 2;
   localparam int SCAN_DIV   = 4;
   localparam int SCROLL_DIV = 16;
   localparam int RING       = ID_LEN + GAP;

   localparam logic [4:0] K_NONE  = 5'b00000;
   localparam logic [4:0] K_INPUT = 5'b10000;
   localparam logic [4:0] K_ENTER = 5'b01000;
   localparam logic [4:0] K_DISP  = 5'b00100;
   localparam logic [4:0] K_WEI   = 5'b00010;
   localparam logic [4:0] K_SHUZI = 5'b00001;

   logic                  clk100mhz = 1'b0;
   logic                  clr       = 1'b1;
   logic                  key_input = 1'b0;
   logic                  key_wei   = 1'b0;
   logic                  key_shuzi = 1'b0;
   logic                  key_enter = 1'b0;
   logic                  key_disp  = 1'b0;
   logic [NUM_DIGITS-1:0] pos;
   logic [7:0]            seg;
   logic [1:0]            mode;
   logic                  id_valid;

   id_scroll_ctrl #(
      .ID_LEN          (ID_LEN),
      .NUM_DIGITS      (NUM_DIGITS),
      .GAP             (GAP),
      .SCAN_DIV        (SCAN_DIV),
      .SCROLL_DIV      (SCROLL_DIV),
      .SEG_ACTIVE_HIGH (1)
   ) dut (
      .clk100mhz (clk100mhz),
      .clr       (clr),
      .key_input (key_input),
      .key_wei   (key_wei),
      .key_shuzi (key_shuzi),
      .key_enter (key_enter),
      .key_disp  (key_disp),
      .pos       (pos),
      .seg       (seg),
      .mode      (mode),
      .id_valid  (id_valid)
   );

   always #5 clk100mhz = ~clk100mhz;

   typedef struct packed {
      logic [31:0]           tag;
      logic [NUM_DIGITS-1:0] pos;
      logic [7:0]            seg;
      logic [1:0]            mode;
      logic                  valid;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_rec;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   // Behavioural model: mode 0/1/2 = idle/edit/show, edge_cnt = edges since clr release
   int m_state;
   int m_cur;
   int m_valid;
   int m_show_edge;
   int edge_cnt;
   int m_buf [ID_LEN];
   int m_id  [ID_LEN];

   function automatic logic [7:0] enc(input int d);
      case (d)
         0: return 8'h3F;
         1: return 8'h06;
         2: return 8'h5B;
         3: return 8'h4F;
         4: return 8'h66;
         5: return 8'h6D;
         6: return 8'h7D;
         7: return 8'h07;
         8: return 8'h7F;
         9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   // Expected segments at position i given the model state as it stood after edge n
   function automatic logic [7:0] exp_seg(input int i, input int n);
      int b;
      int r;
      int off;
      logic [7:0] s;
      s = 8'h00;
      if (m_state == 1) begin
         b = (m_cur / NUM_DIGITS) * NUM_DIGITS + i;
         if (b < ID_LEN) s = enc(m_buf[b]);
         if (b == m_cur) s = s | 8'h80;
      end else if (m_state == 2) begin
         off = ((n - m_show_edge) / SCROLL_DIV) % RING;
         r   = (off + i) % RING;
         if (r < ID_LEN) s = enc(m_id[r]);
      end
      return s;
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_cur       = 0;
      m_valid     = 0;
      m_show_edge = 0;
      edge_cnt    = 0;
      for (int i = 0; i < ID_LEN; i++) begin
         m_buf[i] = 0;
         m_id[i]  = 0;
      end
   endtask

   // Apply one cycle's key pulses to the model, highest priority key only
   task automatic model_key(input logic [4:0] k, input int e);
      if (k[4]) begin
         m_state = 1;
         m_cur   = 0;
         for (int i = 0; i < ID_LEN; i++) m_buf[i] = 0;
      end else if (k[3]) begin
         if (m_state == 1) begin
            for (int i = 0; i < ID_LEN; i++) m_id[i] = m_buf[i];
            m_valid = 1;
            m_state = 0;
         end
      end else if (k[2]) begin
         if (m_state == 0 && m_valid == 1) begin
            m_state     = 2;
            m_show_edge = e;
         end else if (m_state == 2) begin
            m_state = 0;
         end
      end else if (k[1]) begin
         if (m_state == 1) m_cur = (m_cur + 1) % ID_LEN;
      end else if (k[0]) begin
         if (m_state == 1) m_buf[m_cur] = (m_buf[m_cur] + 1) % 10;
      end
   endtask

   // One clock cycle: drive keys, predict outputs after the edge, queue the prediction
   task automatic step(input logic [4:0] k);
      int e;
      int kn;
      int idx;
      exp_t rec;
      e = edge_cnt + 1;
      kn = (e - 1) / SCAN_DIV;
      rec.tag = 32'(e);
      if (kn == 0) begin
         rec.pos = '0;
         rec.seg = 8'h00;
      end else begin
         idx     = (kn - 1) % NUM_DIGITS;
         rec.pos = NUM_DIGITS'(1) << idx;
         rec.seg = exp_seg(idx, e - 1);
      end
      {key_input, key_enter, key_disp, key_wei, key_shuzi} = k;
      model_key(k, e);
      rec.mode  = 2'(m_state);
      rec.valid = (m_valid != 0);
      @(posedge clk100mhz);
      #1;
      {key_input, key_enter, key_disp, key_wei, key_shuzi} = K_NONE;
      edge_cnt = e;
      sb_q.push_back(rec);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(K_NONE);
   endtask

   task automatic check_now(input string name, input logic [NUM_DIGITS-1:0] ep,
                            input logic [7:0] es, input logic [1:0] em, input logic ev);
      chk_cnt++;
      if (pos === ep && seg === es && mode === em && id_valid === ev) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got pos=%h seg=%h mode=%0d id_valid=%0d, want pos=%h seg=%h mode=%0d id_valid=%0d",
                  name, pos, seg, mode, id_valid, ep, es, em, ev);
      end
   endtask

   function automatic logic [4:0] rand_keys();
      logic [4:0] k;
      k[4] = ($urandom_range(0, 15) == 0);
      k[3] = ($urandom_range(0, 7) == 0);
      k[2] = ($urandom_range(0, 6) == 0);
      k[1] = ($urandom_range(0, 4) == 0);
      k[0] = ($urandom_range(0, 2) == 0);
      return k;
   endfunction

   // Monitor: every queued prediction is compared against the DUT on the falling edge
   always @(negedge clk100mhz) begin
      if (sb_q.size() > 0) begin
         mon_rec = sb_q.pop_front();
         chk_cnt++;
         if (pos === mon_rec.pos && seg === mon_rec.seg && mode === mon_rec.mode &&
             id_valid === mon_rec.valid) begin
            pass_cnt++;
         end else begin
            $display("FAIL out edge %0d: got pos=%h seg=%h mode=%0d id_valid=%0d, want pos=%h seg=%h mode=%0d id_valid=%0d",
                     mon_rec.tag, pos, seg, mode, id_valid,
                     mon_rec.pos, mon_rec.seg, mon_rec.mode, mon_rec.valid);
         end
      end
   end

   initial begin
      #200000;
      chk_cnt++;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      model_reset();
      #12;
      check_now("reset_initial", '0, 8'h00, 2'd0, 1'b0);
      @(posedge clk100mhz);
      #1;
      clr = 1'b0;

      // key_disp with no committed ID stays in IDLE
      idle(3);
      step(K_DISP);
      idle(6);

      // entry: 3 at digit 0, 11 increments wrap digit 1 to 1, then show it
      step(K_INPUT);
      idle($urandom_range(0, 3));
      repeat (3) begin
         step(K_SHUZI);
         idle($urandom_range(0, 3));
      end
      step(K_WEI);
      repeat (11) begin
         step(K_SHUZI);
         idle($urandom_range(0, 2));
      end
      step(K_ENTER);
      idle(4);
      step(K_DISP);
      idle(60);
      step(K_DISP);
      idle(4);

      // cursor paging onto the second page
      step(K_INPUT);
      repeat (5) step(K_WEI);
      idle(40);

      // commit 12345678 and scroll through more than one ring revolution
      step(K_INPUT);
      for (int p = 0; p < ID_LEN; p++) begin
         repeat (p + 1) step(K_SHUZI);
         step(K_WEI);
      end
      step(K_ENTER);
      idle(2);
      step(K_DISP);
      idle(200);
      step(K_DISP);
      idle(4);

      // key_input beats key_enter in the same cycle
      step(K_INPUT);
      repeat (4) step(K_SHUZI);
      step(K_INPUT | K_ENTER);
      idle(20);
      step(K_ENTER);
      idle(4);

      // random key traffic, including simultaneous pulses
      repeat (400) step(rand_keys());

      // asynchronous reset in the middle of an edit
      step(K_INPUT);
      step(K_SHUZI);
      idle(20);
      @(negedge clk100mhz);
      #1;
      clr = 1'b1;
      #1;
      check_now("reset_async", '0, 8'h00, 2'd0, 1'b0);
      {key_input, key_enter, key_disp, key_wei, key_shuzi} = K_INPUT | K_DISP;
      @(posedge clk100mhz);
      #1;
      {key_input, key_enter, key_disp, key_wei, key_shuzi} = K_NONE;
      check_now("reset_keys", '0, 8'h00, 2'd0, 1'b0);
      @(posedge clk100mhz);
      #1;
      clr = 1'b0;
      model_reset();
      idle(10);
      step(K_DISP);
      idle(30);

      @(negedge clk100mhz);
      #2;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
